// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_REQ source FIFOs round-robin onto one registered valid/ready output port.
// Latency: grant to out_valid is 2 cycles, so a stream moves at most one word every 2 cycles.
// Backpressure: out_valid/out_data/out_src hold until out_ready. Define FIFO_DRAIN_ARB_PRIORITY0_EN to give source 0 strict priority.
module fifo_drain_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_poweron,
    input  logic                          clear,
    input  logic [NUM_REQ-1:0]            req_enable,
    input  logic [NUM_REQ-1:0]            fifo_empty,
    output logic [NUM_REQ-1:0]            fifo_read,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_read_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_src,
    output logic                          busy
);
    localparam int SRC_WIDTH = $clog2(NUM_REQ);
    localparam logic [SRC_WIDTH-1:0] LAST_IDX = SRC_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [SRC_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SRC_WIDTH-1:0]  out_src_q, out_src_d;
    logic [NUM_REQ-1:0]    eligible, rr_cand;
    logic [SRC_WIDTH-1:0]  pick, scan;
    logic                  pick_found, any_eligible, rd_en;
    logic [DATA_WIDTH-1:0] rd_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign rd_words[g] = fifo_read_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eligible     = req_enable & ~fifo_empty;
    assign any_eligible = |eligible;

`ifdef FIFO_DRAIN_ARB_PRIORITY0_EN
    assign rr_cand = eligible & ~NUM_REQ'(1);
`else
    assign rr_cand = eligible;
`endif

    // Scan starts one past the last grant and wraps; first candidate found wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan       = last_grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (scan == LAST_IDX) ? '0 : scan + SRC_WIDTH'(1);
            if (!pick_found && rr_cand[scan]) begin
                pick       = scan;
                pick_found = 1'b1;
            end
        end
`ifdef FIFO_DRAIN_ARB_PRIORITY0_EN
        if (eligible[0]) begin
            pick = '0;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        rd_en        = 1'b0;
        if (clear) begin
            state_d      = IDLE;
            last_grant_d = LAST_IDX;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_eligible) begin
                        rd_en   = 1'b1;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    // last_grant_q is the source read in the previous cycle.
                    out_data_d = rd_words[last_grant_q];
                    out_src_d  = last_grant_q;
                    state_d    = OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (any_eligible) begin
                            rd_en   = 1'b1;
                            state_d = CAPTURE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (rd_en) begin
                last_grant_d = pick;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_IDX;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    // Gated by reset so no strobe escapes while reset is held.
    assign fifo_read = (rd_en && reset_poweron) ? (NUM_REQ'(1) << pick) : '0;
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Randomized bench for fifo_drain_arbiter: behavioural FIFOs plus a transaction-level arbitration model.
module tb_fifo_drain_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_poweron, clear, out_ready;
    logic [N-1:0]  req_enable, fifo_empty, fifo_read;
    logic [N*DW-1:0] fifo_read_data;
    logic          out_valid, busy;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] srcq [N][$];
    int            pend_src [$];
    logic [DW-1:0] pend_dat [$];

    bit            m_inflight = 0;
    int            m_age = 0;
    int            m_last = N - 1;
    int            m_src = 0;
    logic [DW-1:0] m_data = '0;
    int            cyc = 0;
    int            reads_seen = 0;
    int            last_rd = -1;
    int            acc_src [$];
    int            acc_cyc [$];

    fifo_drain_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset_poweron  (reset_poweron),
        .clear          (clear),
        .req_enable     (req_enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .fifo_read_data (fifo_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_src        (out_src),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arbitration rule: first eligible source after the last grant, wrapping; optional source-0 priority.
    function automatic int model_pick(input logic [N-1:0] el, input int last);
        int p;
        p = -1;
`ifdef FIFO_DRAIN_ARB_PRIORITY0_EN
        if (el[0]) return 0;
        el[0] = 1'b0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (p < 0 && el[(last + k) % N]) p = (last + k) % N;
        end
        return p;
    endfunction

    // Source FIFOs: one-cycle read latency, new words become visible at the next edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_read[i] && srcq[i].size() > 0)
                fifo_read_data[i*DW +: DW] <= srcq[i].pop_front();
        end
        while (pend_src.size() > 0) begin
            srcq[pend_src.pop_front()].push_back(pend_dat.pop_front());
        end
        for (int i = 0; i < N; i++) fifo_empty[i] <= (srcq[i].size() == 0);
    end

    always @(negedge clk) begin : mon
        logic [N-1:0] el;
        logic [N-1:0] exp_rd;
        bit           exp_vld, hs;
        int           p;
        cyc++;
        if (!reset_poweron) begin
            check("rst_fifo_read", fifo_read, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_src", out_src, 0);
            m_inflight = 0;
            m_last = N - 1;
        end else begin
            for (int i = 0; i < N; i++) el[i] = req_enable[i] && (srcq[i].size() > 0);
            exp_vld = m_inflight && (m_age >= 2);
            hs = exp_vld && out_ready;
            p = model_pick(el, m_last);
            exp_rd = '0;
            if (!clear && p >= 0 && (!m_inflight || hs)) exp_rd[p] = 1'b1;
            check("fifo_read", fifo_read, exp_rd);
            check("out_valid", out_valid, exp_vld);
            check("busy", busy, m_inflight);
            if (exp_vld) begin
                check("out_data", out_data, m_data);
                check("out_src", out_src, m_src);
            end
            if (clear) begin
                m_inflight = 0;
                m_last = N - 1;
            end else begin
                if (hs) begin
                    acc_src.push_back(m_src);
                    acc_cyc.push_back(cyc);
                    m_inflight = 0;
                end
                if (exp_rd != 0) begin
                    m_inflight = 1;
                    m_age = 0;
                    m_data = srcq[p][0];
                    m_src = p;
                    m_last = p;
                end
            end
            if (fifo_read != 0) begin
                reads_seen++;
                for (int i = 0; i < N; i++) if (fifo_read[i]) last_rd = i;
            end
            if (m_inflight) m_age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input logic [DW-1:0] w);
        pend_src.push_back(s);
        pend_dat.push_back(w);
    endtask

    task automatic wait_read(input string tag);
        int r0;
        r0 = reads_seen;
        for (int i = 0; i < 50 && reads_seen == r0; i++) tick();
        if (reads_seen == r0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        out_ready = 1'b1;
        req_enable = '1;
        clear = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = (pend_src.size() == 0) && !busy && !m_inflight;
            for (int s = 0; s < N; s++) if (srcq[s].size() != 0) done = 0;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_poweron = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        req_enable = '1;
        fifo_empty = '1;
        fifo_read_data = '0;
        repeat (3) tick();
        reset_poweron = 1'b1;

        // Idle with all FIFOs empty.
        repeat (20) tick();
        check("idle_reads", reads_seen, 0);

        // Streaming: 2 words per source, out_ready tied high.
        out_ready = 1'b1;
        acc_src.delete();
        acc_cyc.delete();
        for (int w = 0; w < 8; w++) push(w % 4, 32'h1000_0000 + w);
        repeat (30) tick();
        check("stream_count", acc_src.size(), 8);
        for (int k = 0; k < acc_src.size(); k++) begin
            check("stream_src", acc_src[k], k % 4);
            if (k > 0) check("stream_gap", acc_cyc[k] - acc_cyc[k-1], 2);
        end

        // Stall with source 2's word on the output while source 0 waits.
        out_ready = 1'b0;
        push(2, 32'hA5A5_0002);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        check("stall_valid", out_valid, 1);
        push(0, 32'h0000_00C0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", out_data, 32'hA5A5_0002);
            check("stall_src", out_src, 2);
            check("stall_no_read", fifo_read, 0);
        end
        drain();

        // Source 1 masked by req_enable.
        req_enable = 4'b1101;
        out_ready = 1'b1;
        begin
            int r0;
            r0 = reads_seen;
            push(1, 32'h0000_0B01);
            repeat (6) tick();
            check("masked_no_read", reads_seen, r0);
            req_enable = '1;
            tick();
            check("unmask_read", reads_seen, r0 + 1);
            check("unmask_src", last_rd, 1);
        end
        drain();

        // Clear in CAPTURE resets the round-robin pointer.
        push(2, 32'h0000_0C02);
        wait_read("clr_first");
        clear = 1'b1;
        push(0, 32'h0000_0C00);
        push(3, 32'h0000_0C03);
        tick();
        clear = 1'b0;
        check("clr_valid_low", out_valid, 0);
        check("clr_busy_low", busy, 0);
        wait_read("clr_next");
        check("clr_grant0", last_rd, 0);
        drain();

`ifdef FIFO_DRAIN_ARB_PRIORITY0_EN
        // Source 0 wins every grant while it has data.
        acc_src.delete();
        for (int w = 0; w < 4; w++) begin
            push(0, 32'hD000_0000 + w);
            push(3, 32'hD300_0000 + w);
        end
        drain();
        check("prio_count", acc_src.size(), 8);
        for (int k = 0; k < acc_src.size(); k++) check("prio_src", acc_src[k], (k < 4) ? 0 : 3);
`endif

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(2, 0) == 0) begin
                int s;
                s = $urandom_range(N - 1, 0);
                if (srcq[s].size() < 8) push(s, $urandom);
            end
            if ($urandom_range(15, 0) == 0) req_enable = N'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            clear = ($urandom_range(63, 0) == 0);
            tick();
        end
        clear = 1'b0;
        drain();

        // Reset while a word is waiting on the output.
        out_ready = 1'b0;
        push(1, 32'hE000_0001);
        push(1, 32'hE000_0002);
        push(3, 32'hE000_0003);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        check("prerst_valid", out_valid, 1);
        reset_poweron = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_read", fifo_read, 0);
        repeat (3) tick();
        reset_poweron = 1'b1;
        out_ready = 1'b1;
        wait_read("postrst");
        check("postrst_lowest", last_rd, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
